// File: rtl/speed_report_pkg.sv
// Shared constants, FSM state type and baud-divider helper for the speed report
// UART path.
package speed_report_pkg;

    localparam logic [7:0]  FRAME_HDR   = 8'hA5;
    localparam int unsigned FRAME_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned sys_freq,
                                                 input int unsigned baud);
        return sys_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with a valid/ready handshake. A byte offered during the
// last stop-bit cycle is loaded straight into the next start bit.
module uart_tx_byte
    import speed_report_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy
);

    localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_baud, w_baud_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_line, w_line_nxt;
    logic             w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign tx_ready  = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign tx_line   = r_line;
    assign tx_busy   = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = START;
                    w_shift_nxt = tx_data;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (tx_valid) begin
                        w_state_nxt = START;
                        w_shift_nxt = tx_data;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
        endcase
    end

    // Line level is decoded from the next state so the pin itself is a flop.
    always_comb begin
        w_line_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_line_nxt = 1'b0;
            DATA:    w_line_nxt = w_shift_nxt[0];
            default: ;
        endcase
    end

endmodule

// File: rtl/speed_report_tx.sv
// Captures a speed/E-pass result on done and streams it as a 5-byte
// checksummed frame over 8N1 UART; reports strobes lost while a frame is active.
module speed_report_tx
    import speed_report_pkg::*;
#(
    parameter int unsigned SYS_FREQ    = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned WIDTH_SPEED = 14
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic [1:0]             valid_Epass,
    output logic                   serial_data_out,
    output logic                   busy,
    output logic                   drop
);

    localparam int unsigned CPB = clks_per_bit(SYS_FREQ, BAUD);

    logic [7:0]  r_frame [FRAME_BYTES];
    logic [2:0]  r_byte_idx;
    logic        r_active;
    logic        r_sent_all;
    logic        r_drop;

    logic [15:0] w_speed16;
    logic [7:0]  w_b1, w_b2, w_b3;
    logic        w_capture;
    logic        w_tx_valid, w_tx_ready, w_hs;
    logic        w_tx_line, w_tx_busy;

    assign w_speed16  = 16'(speed);
    assign w_b1       = w_speed16[15:8];
    assign w_b2       = w_speed16[7:0];
    assign w_b3       = {6'b0, valid_Epass};
    assign w_capture  = done && !r_active;
    assign w_tx_valid = r_active && !r_sent_all;
    assign w_hs       = w_tx_valid && w_tx_ready;

    // r_active spans capture to the end of the last stop bit, so a strobe in
    // that final stop cycle is still dropped while the next cycle accepts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_sent_all <= 1'b0;
            r_byte_idx <= '0;
            r_drop     <= 1'b0;
            for (int unsigned i = 0; i < FRAME_BYTES; i++) r_frame[i] <= '0;
        end else begin
            r_drop <= done && r_active;
            if (w_capture) begin
                r_active   <= 1'b1;
                r_sent_all <= 1'b0;
                r_byte_idx <= '0;
                r_frame[0] <= FRAME_HDR;
                r_frame[1] <= w_b1;
                r_frame[2] <= w_b2;
                r_frame[3] <= w_b3;
                r_frame[4] <= FRAME_HDR ^ w_b1 ^ w_b2 ^ w_b3;
            end else if (r_active) begin
                if (w_hs) begin
                    if (r_byte_idx == 3'(FRAME_BYTES - 1)) r_sent_all <= 1'b1;
                    else                                    r_byte_idx <= r_byte_idx + 3'd1;
                end
                if (r_sent_all && w_tx_ready) r_active <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CPB)
    ) u_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_valid (w_tx_valid),
        .tx_data  (r_frame[r_byte_idx]),
        .tx_ready (w_tx_ready),
        .tx_line  (w_tx_line),
        .tx_busy  (w_tx_busy)
    );

    assign serial_data_out = w_tx_line;
    assign busy            = w_tx_busy;
    assign drop            = r_drop;

endmodule

// File: tb/tb_speed_report_tx.sv
// Directed self-checking bench for speed_report_tx at 10 clocks per bit.
module tb_speed_report_tx;

    logic        clk;
    logic        reset_n;
    logic        done;
    logic [13:0] speed;
    logic [1:0]  valid_Epass;
    logic        serial_data_out;
    logic        busy;
    logic        drop;

    int checks = 0;
    int errors = 0;

    speed_report_tx #(
        .SYS_FREQ    (50000000),
        .BAUD        (5000000),
        .WIDTH_SPEED (14)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .done            (done),
        .speed           (speed),
        .valid_Epass     (valid_Epass),
        .serial_data_out (serial_data_out),
        .busy            (busy),
        .drop            (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k counts falling edges after the strobe; k=1 follows the capture edge N.
    // Bit i of the frame is expected on k = 2+10i .. 11+10i.
    task automatic run_frame(input string nm, input logic [13:0] spd, input logic [1:0] ep,
                             input logic [39:0] exp_bytes, input bit armed,
                             input int dup_k, input int chg_k, input int rst_k,
                             input bit chain, input logic [13:0] nspd, input logic [1:0] nep);
        logic [49:0] stream;
        logic [7:0]  rx [5];
        logic [7:0]  eb;
        int          busy_cnt, drop_cnt, drop_k, line_err, bi;
        busy_cnt = 0; drop_cnt = 0; drop_k = 0; line_err = 0;
        for (int b = 0; b < 5; b++) begin
            eb = exp_bytes[39-8*b -: 8];
            stream[10*b] = 1'b0;
            for (int j = 0; j < 8; j++) stream[10*b+1+j] = eb[j];
            stream[10*b+9] = 1'b1;
            rx[b] = 8'h00;
        end
        if (!armed) begin
            @(negedge clk);
            speed = spd; valid_Epass = ep; done = 1'b1;
        end
        for (int k = 1; k <= 502; k++) begin
            @(negedge clk);
            if (rst_k > 0 && k == rst_k + 1) begin
                checks++;
                if (serial_data_out !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s reset_abort: line=%b busy=%b, required line=1 busy=0",
                             nm, serial_data_out, busy);
                end
                reset_n = 1'b1;
                return;
            end
            if (k == 1) begin
                checks++;
                if (serial_data_out !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pre_start: line=%b busy=%b, required line=1 busy=0",
                             nm, serial_data_out, busy);
                end
            end
            if (k == 2) begin
                checks++;
                if (serial_data_out !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start_edge: line=%b busy=%b, required line=0 busy=1",
                             nm, serial_data_out, busy);
                end
            end
            if (busy === 1'b1) busy_cnt++;
            if (drop === 1'b1) begin
                if (drop_cnt == 0) drop_k = k;
                drop_cnt++;
            end
            if (k >= 2 && k <= 501) begin
                bi = (k - 2) / 10;
                if (serial_data_out !== stream[bi]) line_err++;
                if ((k - 2) % 10 == 5 && (bi % 10) >= 1 && (bi % 10) <= 8)
                    rx[bi/10][(bi%10)-1] = serial_data_out;
            end
            if (k == 502) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_fall: busy=%b, required 0", nm, busy);
                end
            end
            done = (k == dup_k);
            if (k == dup_k) begin speed = 14'h1234; valid_Epass = 2'b11; end
            if (k == chg_k) speed = 14'h1FFF;
            if (k == rst_k) reset_n = 1'b0;
            if (k == 502 && chain) begin speed = nspd; valid_Epass = nep; done = 1'b1; end
        end
        checks++;
        if (busy_cnt != 500) begin
            errors++;
            $display("FAIL %s busy_len: got %0d cycles, required 500", nm, busy_cnt);
        end
        checks++;
        if (line_err != 0) begin
            errors++;
            $display("FAIL %s line_timing: %0d cycles off, required 0", nm, line_err);
        end
        for (int b = 0; b < 5; b++) begin
            eb = exp_bytes[39-8*b -: 8];
            checks++;
            if (rx[b] !== eb) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h, required %02h", nm, b, rx[b], eb);
            end
        end
        checks++;
        if (drop_cnt != ((dup_k > 0) ? 1 : 0) || (dup_k > 0 && drop_k != dup_k + 1)) begin
            errors++;
            $display("FAIL %s drop: %0d pulses at k=%0d, required %0d at k=%0d",
                     nm, drop_cnt, drop_k, (dup_k > 0) ? 1 : 0, dup_k + 1);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        reset_n = 1'b0; done = 1'b0; speed = '0; valid_Epass = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (serial_data_out !== 1'b1 || busy !== 1'b0 || drop !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d non-idle cycles (last line=%b busy=%b drop=%b), required 0",
                     bad, serial_data_out, busy, drop);
        end
    endtask

    task automatic test_single_frame();
        run_frame("single", 14'h0123, 2'b10, 40'hA5_01_23_02_85, 1'b0, 0, 0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 14'h0123, 2'b10, 40'hA5_01_23_02_85, 1'b0, 0, 0, 0,
                  1'b1, 14'h3FFF, 2'b01);
        run_frame("b2b_saturated", 14'h3FFF, 2'b01, 40'hA5_3F_FF_01_64, 1'b1, 0, 0, 0,
                  1'b0, '0, '0);
    endtask

    task automatic test_overlap_drop();
        run_frame("overlap200", 14'h0ABC, 2'b00, 40'hA5_0A_BC_00_13, 1'b0, 200, 0, 0,
                  1'b0, '0, '0);
    endtask

    task automatic test_last_stop_drop();
        int bad;
        bad = 0;
        run_frame("last_stop", 14'h0123, 2'b10, 40'hA5_01_23_02_85, 1'b0, 501, 0, 0,
                  1'b0, '0, '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (serial_data_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL last_stop_idle: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_with_done();
        int bad;
        bad = 0;
        @(negedge clk);
        reset_n = 1'b0; done = 1'b1; speed = 14'h0777; valid_Epass = 2'b01;
        @(negedge clk);
        reset_n = 1'b1; done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (serial_data_out !== 1'b1 || busy !== 1'b0 || drop !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_with_done: %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        bad = 0;
        run_frame("mid_reset", 14'h0123, 2'b10, 40'hA5_01_23_02_85, 1'b0, 0, 0, 245,
                  1'b0, '0, '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (serial_data_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_idle: %0d active cycles, required 0", bad);
        end
        run_frame("after_reset", 14'h0123, 2'b10, 40'hA5_01_23_02_85, 1'b0, 0, 0, 0,
                  1'b0, '0, '0);
    endtask

    task automatic test_input_change();
        run_frame("input_change", 14'h0050, 2'b11, 40'hA5_00_50_03_F6, 1'b0, 0, 1, 0,
                  1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overlap_drop();
        test_last_stop_drop();
        test_reset_with_done();
        test_reset_mid_frame();
        test_input_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
